// File: rtl/pipe_ctrl_if.sv
// Control-path bundle between the decode/EX datapath and the pipeline sequencer.
// Slave is the sequencer view; master is the datapath/driver view.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic             id_regwrite;
    logic [1:0]       id_resultsrc;
    logic             id_memwrite;
    logic             id_branch;
    logic             id_jump;
    logic             id_alusrca;
    logic             id_alusrcb;
    logic [2:0]       id_aluctrl;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             ex_zero;

    logic             ex_regwrite;
    logic [1:0]       ex_resultsrc;
    logic             ex_memwrite;
    logic             ex_branch;
    logic             ex_jump;
    logic             ex_alusrca;
    logic             ex_alusrcb;
    logic [2:0]       ex_aluctrl;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_pcsrc;
    logic             mem_regwrite;
    logic [1:0]       mem_resultsrc;
    logic             mem_memwrite;
    logic [4:0]       mem_rd;
    logic             wb_regwrite;
    logic [1:0]       wb_resultsrc;
    logic [4:0]       wb_rd;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_valid, id_regwrite, id_resultsrc, id_memwrite, id_branch, id_jump,
               id_alusrca, id_alusrcb, id_aluctrl, id_rs1, id_rs2, id_rd, ex_zero,
        output ex_regwrite, ex_resultsrc, ex_memwrite, ex_branch, ex_jump, ex_alusrca,
               ex_alusrcb, ex_aluctrl, ex_rs1, ex_rs2, ex_rd, ex_pcsrc,
               mem_regwrite, mem_resultsrc, mem_memwrite, mem_rd,
               wb_regwrite, wb_resultsrc, wb_rd, fwd_a, fwd_b,
               stall_f, stall_d, flush_d, flush_e, stall_cnt, flush_cnt
    );

    modport master (
        output id_valid, id_regwrite, id_resultsrc, id_memwrite, id_branch, id_jump,
               id_alusrca, id_alusrcb, id_aluctrl, id_rs1, id_rs2, id_rd, ex_zero,
        input  ex_regwrite, ex_resultsrc, ex_memwrite, ex_branch, ex_jump, ex_alusrca,
               ex_alusrcb, ex_aluctrl, ex_rs1, ex_rs2, ex_rd, ex_pcsrc,
               mem_regwrite, mem_resultsrc, mem_memwrite, mem_rd,
               wb_regwrite, wb_resultsrc, wb_rd, fwd_a, fwd_b,
               stall_f, stall_d, flush_d, flush_e, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage control sequencer: ID/EX, EX/MEM, MEM/WB control regs, hazards, forwarding, perf counters.
// Latency 1 cycle per stage; no downstream backpressure, load-use stalls F/D and redirects flush D/E.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    pipe_ctrl_if.slave  bus
);
    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       alusrca;
        logic       alusrcb;
        logic [2:0] aluctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [4:0] rd;
    } wb_t;

    ctrl_t            ex_q, ex_d, id_bundle;
    mem_t             mem_q, mem_d;
    wb_t              wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             pcsrc, lwstall, flush_e;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input mem_t m, input wb_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (m.regwrite && (m.rd != 5'd0) && (m.rd == rs))
            sel = 2'b10;
        else if (w.regwrite && (w.rd != 5'd0) && (w.rd == rs))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        id_bundle = {bus.id_regwrite, bus.id_resultsrc, bus.id_memwrite, bus.id_branch,
                     bus.id_jump, bus.id_alusrca, bus.id_alusrcb, bus.id_aluctrl,
                     bus.id_rs1, bus.id_rs2, bus.id_rd};

        pcsrc   = ex_q.jump | (ex_q.branch & bus.ex_zero);
        // Deliberately conservative: any source match against a pending load stalls.
        lwstall = bus.id_valid && (ex_q.resultsrc == 2'b01) && (ex_q.rd != 5'd0) &&
                  ((bus.id_rs1 == ex_q.rd) || (bus.id_rs2 == ex_q.rd));
        flush_e = lwstall | pcsrc;

        // Invalid decode slots select the bubble so undriven id_ fields never reach state.
        ex_d  = (flush_e || !bus.id_valid) ? ctrl_t'('0) : id_bundle;
        mem_d = {ex_q.regwrite, ex_q.resultsrc, ex_q.memwrite, ex_q.rd};
        wb_d  = {mem_q.regwrite, mem_q.resultsrc, mem_q.rd};

        stall_cnt_d = stall_cnt_q;
        if (lwstall && !pcsrc && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        flush_cnt_d = flush_cnt_q;
        if (pcsrc && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ex_regwrite   = ex_q.regwrite;
    assign bus.ex_resultsrc  = ex_q.resultsrc;
    assign bus.ex_memwrite   = ex_q.memwrite;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_jump       = ex_q.jump;
    assign bus.ex_alusrca    = ex_q.alusrca;
    assign bus.ex_alusrcb    = ex_q.alusrcb;
    assign bus.ex_aluctrl    = ex_q.aluctrl;
    assign bus.ex_rs1        = ex_q.rs1;
    assign bus.ex_rs2        = ex_q.rs2;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_pcsrc      = pcsrc;
    assign bus.mem_regwrite  = mem_q.regwrite;
    assign bus.mem_resultsrc = mem_q.resultsrc;
    assign bus.mem_memwrite  = mem_q.memwrite;
    assign bus.mem_rd        = mem_q.rd;
    assign bus.wb_regwrite   = wb_q.regwrite;
    assign bus.wb_resultsrc  = wb_q.resultsrc;
    assign bus.wb_rd         = wb_q.rd;
    assign bus.fwd_a         = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign bus.fwd_b         = fwd_sel(ex_q.rs2, mem_q, wb_q);
    assign bus.stall_f       = lwstall & ~pcsrc;
    assign bus.stall_d       = lwstall & ~pcsrc;
    assign bus.flush_d       = pcsrc;
    assign bus.flush_e       = flush_e;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: reference model of the control pipe, expected stage contents
// queued at drive time and compared one clock later, plus directed hazard/forwarding checks.
module tb_pipe_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       alusrca;
        logic       alusrcb;
        logic [2:0] aluctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_t;
    typedef struct packed { logic rw; logic [1:0] rs; logic mw; logic [4:0] rd; } mem_t;
    typedef struct packed { logic rw; logic [1:0] rs; logic [4:0] rd; } wb_t;
    typedef struct packed {
        ctrl_t ex; mem_t mem; wb_t wb; logic [CW-1:0] sc; logic [CW-1:0] fc;
    } exp_t;

    exp_t          sb[$];
    ctrl_t         m_ex;
    mem_t          m_mem;
    wb_t           m_wb;
    logic [CW-1:0] m_sc, m_fc;
    logic          m_pc, m_lw;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (m_mem.rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.rw && m_wb.rd != 0 && m_wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_sc = '0; m_fc = '0;
        sb.delete();
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic br, input logic jp, input logic [2:0] alu,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        bus.id_valid = v;       bus.id_regwrite = rw;   bus.id_resultsrc = rs;
        bus.id_memwrite = mw;   bus.id_branch = br;     bus.id_jump = jp;
        bus.id_alusrca = alu[2]; bus.id_alusrcb = alu[0]; bus.id_aluctrl = alu;
        bus.id_rs1 = r1;        bus.id_rs2 = r2;        bus.id_rd = rd;
        bus.ex_zero = 1'b0;
    endtask

    task automatic nop();       drive(0, $urandom, 2'($urandom), $urandom, $urandom, $urandom,
                                      3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)); endtask
    task automatic rtype(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        drive(1, 1, 2'b00, 0, 0, 0, 3'b010, r1, r2, rd); endtask
    task automatic lw(input logic [4:0] rd, input logic [4:0] r1);
        drive(1, 1, 2'b01, 0, 0, 0, 3'b001, r1, 5'd0, rd); endtask
    task automatic beq(input logic [4:0] r1, input logic [4:0] r2);
        drive(1, 0, 2'b00, 0, 1, 0, 3'b100, r1, r2, 5'd0); endtask
    task automatic jal(input logic [4:0] rd);
        drive(1, 1, 2'b10, 0, 0, 1, 3'b101, 5'd0, 5'd0, rd); endtask

    // Combinational checks against the model for the currently driven decode slot.
    task automatic eval();
        #2;
        m_pc = m_ex.jump | (m_ex.branch & bus.ex_zero);
        m_lw = bus.id_valid && m_ex.resultsrc == 2'b01 && m_ex.rd != 0 &&
               (bus.id_rs1 == m_ex.rd || bus.id_rs2 == m_ex.rd);
        chk("pcsrc",   bus.ex_pcsrc, m_pc);
        chk("stall_f", bus.stall_f, m_lw & ~m_pc);
        chk("stall_d", bus.stall_d, m_lw & ~m_pc);
        chk("flush_d", bus.flush_d, m_pc);
        chk("flush_e", bus.flush_e, m_lw | m_pc);
        chk("fwd_a",   bus.fwd_a, ref_fwd(m_ex.rs1));
        chk("fwd_b",   bus.fwd_b, ref_fwd(m_ex.rs2));
    endtask

    task automatic tick();
        exp_t e, g;
        e.ex  = (m_lw || m_pc || !bus.id_valid) ? ctrl_t'('0) :
                {bus.id_regwrite, bus.id_resultsrc, bus.id_memwrite, bus.id_branch, bus.id_jump,
                 bus.id_alusrca, bus.id_alusrcb, bus.id_aluctrl, bus.id_rs1, bus.id_rs2, bus.id_rd};
        e.mem = {m_ex.regwrite, m_ex.resultsrc, m_ex.memwrite, m_ex.rd};
        e.wb  = {m_mem.rw, m_mem.rs, m_mem.rd};
        e.sc  = (m_lw && !m_pc && m_sc != '1) ? m_sc + 1'b1 : m_sc;
        e.fc  = (m_pc && m_fc != '1) ? m_fc + 1'b1 : m_fc;
        sb.push_back(e);
        m_ex = e.ex; m_mem = e.mem; m_wb = e.wb; m_sc = e.sc; m_fc = e.fc;
        @(posedge clk);
        #1;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() != 0) begin
            g = sb.pop_front();
            chk("ex_bundle", {bus.ex_regwrite, bus.ex_resultsrc, bus.ex_memwrite, bus.ex_branch,
                bus.ex_jump, bus.ex_alusrca, bus.ex_alusrcb, bus.ex_aluctrl, bus.ex_rs1,
                bus.ex_rs2, bus.ex_rd}, g.ex);
            chk("mem_stage", {bus.mem_regwrite, bus.mem_resultsrc, bus.mem_memwrite, bus.mem_rd}, g.mem);
            chk("wb_stage", {bus.wb_regwrite, bus.wb_resultsrc, bus.wb_rd}, g.wb);
            chk("stall_cnt", bus.stall_cnt, g.sc);
            chk("flush_cnt", bus.flush_cnt, g.fc);
        end
    endtask

    task automatic cycle(); eval(); tick(); endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex"}, {bus.ex_regwrite, bus.ex_resultsrc, bus.ex_memwrite, bus.ex_branch,
            bus.ex_jump, bus.ex_alusrca, bus.ex_alusrcb, bus.ex_aluctrl, bus.ex_rs1, bus.ex_rs2,
            bus.ex_rd}, 0);
        chk({tag, "_mem"}, {bus.mem_regwrite, bus.mem_resultsrc, bus.mem_memwrite, bus.mem_rd}, 0);
        chk({tag, "_wb"}, {bus.wb_regwrite, bus.wb_resultsrc, bus.wb_rd}, 0);
        chk({tag, "_haz"}, {bus.ex_pcsrc, bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e}, 0);
        chk({tag, "_cnt"}, {bus.stall_cnt, bus.flush_cnt}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;

        // In-flight reset with a load in EX and an R-type in MEM
        rtype(5'd3, 5'd1, 5'd2); cycle();
        lw(5'd4, 5'd1);          cycle();
        chk("mid_ex_lw", bus.ex_resultsrc, 2'b01);
        chk("mid_mem_rw", bus.mem_regwrite, 1);
        rtype(5'd6, 5'd1, 5'd2);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        nop();
        reset_n = 1'b1;
        cycle(); cycle();
        chk_all_zero("post_rst");

        // Load-use: one-cycle stall then the dependent proceeds
        lw(5'd5, 5'd1); cycle();
        rtype(5'd8, 5'd1, 5'd5); eval();
        chk("lu_stall_f", bus.stall_f, 1);
        chk("lu_stall_d", bus.stall_d, 1);
        chk("lu_flush_e", bus.flush_e, 1);
        tick();
        chk("lu_bubble", {bus.ex_regwrite, bus.ex_rd}, 0);
        chk("lu_cnt", bus.stall_cnt, 1);
        eval();
        chk("lu_release", bus.stall_f, 0);
        tick();
        chk("lu_ex_rd", bus.ex_rd, 8);

        lw(5'd0, 5'd1); cycle();
        rtype(5'd9, 5'd0, 5'd0); eval();
        chk("x0_nostall", bus.stall_d, 0);
        tick();

        // Branch taken / not taken / jal
        beq(5'd1, 5'd2); cycle();
        rtype(5'd10, 5'd1, 5'd2); bus.ex_zero = 1'b1; eval();
        chk("br_pcsrc", bus.ex_pcsrc, 1);
        chk("br_flush", {bus.flush_d, bus.flush_e, bus.stall_f}, 3'b110);
        tick();
        chk("br_bubble", {bus.ex_regwrite, bus.ex_rd}, 0);
        chk("br_cnt", bus.flush_cnt, 1);
        beq(5'd1, 5'd2); cycle();
        rtype(5'd11, 5'd1, 5'd2); eval();
        chk("nt_pcsrc", {bus.ex_pcsrc, bus.flush_e}, 0);
        tick();
        chk("nt_ex_rd", bus.ex_rd, 11);
        jal(5'd1); cycle();
        rtype(5'd12, 5'd3, 5'd4); eval();
        chk("jal_pcsrc", bus.ex_pcsrc, 1);
        tick();

        // Redirect and load-use coincide: redirect owns F/D
        drive(1, 1, 2'b01, 0, 0, 1, 3'b000, 5'd0, 5'd0, 5'd5); cycle();
        rtype(5'd13, 5'd5, 5'd0); eval();
        chk("coinc_stall", {bus.stall_f, bus.stall_d}, 0);
        chk("coinc_flush", {bus.flush_d, bus.flush_e}, 2'b11);
        tick();

        // Forwarding priority on both operands
        rtype(5'd7, 5'd1, 5'd2); cycle();
        rtype(5'd7, 5'd1, 5'd2); cycle();
        rtype(5'd14, 5'd7, 5'd7); cycle();
        chk("fwd_a_mem", bus.fwd_a, 2'b10);
        chk("fwd_b_mem", bus.fwd_b, 2'b10);
        rtype(5'd7, 5'd1, 5'd2); cycle();
        drive(1, 0, 2'b00, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd7); cycle();
        rtype(5'd15, 5'd7, 5'd7); cycle();
        chk("fwd_a_wb", bus.fwd_a, 2'b01);
        chk("fwd_b_wb", bus.fwd_b, 2'b01);
        rtype(5'd0, 5'd1, 5'd2); cycle();
        rtype(5'd0, 5'd1, 5'd2); cycle();
        rtype(5'd16, 5'd0, 5'd0); cycle();
        chk("fwd_a_x0", bus.fwd_a, 2'b00);
        chk("fwd_b_x0", bus.fwd_b, 2'b00);

        // Stage latency
        rtype(5'd9, 5'd1, 5'd2); cycle();
        chk("lat_ex", bus.ex_rd, 9);
        nop(); cycle();
        chk("lat_mem", {bus.mem_regwrite, bus.mem_rd}, {1'b1, 5'd9});
        nop(); cycle();
        chk("lat_wb", {bus.wb_regwrite, bus.wb_rd}, {1'b1, 5'd9});

        // Random valid/bubble mix
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) nop();
            else drive(1, $urandom, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                       3'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)));
            bus.ex_zero = 1'($urandom);
            cycle();
        end

        // Flush counter saturation
        for (int i = 0; i < 40; i++) begin
            jal(5'd1); cycle();
        end
        chk("fc_sat", bus.flush_cnt, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
